text_console: RTL and testbench

// Multi-client character writer feeding the textmode display write port (char_x/char_y/char_chr/char_str).

---
 rtl/flapjack_text_pkg.sv | 47 ++++
 rtl/text_console_if.sv | 30 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/text_console.sv | 135 +++++++++++++
 tb/tb_text_console.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flapjack_text_pkg.sv
// Shared types for the text console: command opcodes, cursor struct and cursor stepping helpers.
package flapjack_text_pkg;

    typedef enum logic [1:0] {
        OP_PUT_AT  = 2'd0,
        OP_PUT     = 2'd1,
        OP_NEWLINE = 2'd2,
        OP_CLEAR   = 2'd3
    } text_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } con_state_t;

    localparam int COLS_DEF  = 80;
    localparam int ROWS_DEF  = 60;
    localparam int CHR_W_DEF = 9;
    localparam int XW        = $clog2(COLS_DEF);
    localparam int YW        = $clog2(ROWS_DEF);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cursor_t;

    // Wrap is decided by comparing against the last index, so x never reaches cols.
    function automatic cursor_t cursor_step(cursor_t c, int cols, int rows);
        cursor_t n;
        n = c;
        if (int'(c.x) == cols - 1) begin
            n.x = '0;
            n.y = (int'(c.y) == rows - 1) ? '0 : c.y + YW'(1);
        end else begin
            n.x = c.x + XW'(1);
        end
        return n;
    endfunction

    function automatic cursor_t cursor_newline(cursor_t c, int rows);
        cursor_t n;
        n.x = '0;
        n.y = (int'(c.y) == rows - 1) ? '0 : c.y + YW'(1);
        return n;
    endfunction

endpackage

// File: rtl/text_console_if.sv
// Client command bus plus display write port of the text console.
// Handshake: a command transfers on a clock edge where req_valid[i] & req_ready[i] are both high.
interface text_console_if import flapjack_text_pkg::*; #(
    parameter int N     = 2,
    parameter int CHR_W = CHR_W_DEF
);
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N-1:0][1:0]       req_op;
    logic [N-1:0][XW-1:0]    req_x;
    logic [N-1:0][YW-1:0]    req_y;
    logic [N-1:0][CHR_W-1:0] req_chr;
    logic [XW-1:0]           char_x;
    logic [YW-1:0]           char_y;
    logic [CHR_W-1:0]        char_chr;
    logic                    char_str;
    logic                    busy;
    logic                    range_err;
    con_state_t              state_dbg;

    modport master (
        output req_valid, req_op, req_x, req_y, req_chr,
        input  req_ready, char_x, char_y, char_chr, char_str, busy, range_err, state_dbg
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_chr,
        output req_ready, char_x, char_y, char_chr, char_str, busy, range_err, state_dbg
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the client after the last winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx_w;
    int            idx;

    // Walk offsets from far to near so the client closest to ptr wins.
    always_comb begin
        grant = '0;
        win   = ptr;
        idx   = 0;
        idx_w = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            idx_w = PW'(idx);
            if (req[idx_w]) begin
                grant        = '0;
                grant[idx_w] = 1'b1;
                win          = idx_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(win) == N - 1) ? '0 : win + PW'(1);
        end
    end
endmodule

// File: rtl/text_console.sv
// Multi-client character writer: arbitrates client commands, tracks per-client cursors
// and drives the textmode write port, including a full-screen CLEAR raster.
module text_console import flapjack_text_pkg::*; #(
    parameter int N_CLIENTS = 2,
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int CHR_W     = CHR_W_DEF
) (
    input logic           clk_sys,
    input logic           rst_sys,
    text_console_if.slave tc
);
    localparam int SW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam cursor_t LAST = '{x: XW'(COLS - 1), y: YW'(ROWS - 1)};

    con_state_t           state, state_nxt;
    logic [N_CLIENTS-1:0] grant;
    logic                 accept_en, accept, in_range;
    logic [SW-1:0]        sel;
    text_op_t             sel_op;
    logic [CHR_W-1:0]     sel_chr;
    cursor_t              sel_at, sel_cur, clr_pos, clr_nxt;
    cursor_t              cur [N_CLIENTS];
    logic [CHR_W-1:0]     clr_chr;
    logic [XW-1:0]        x_q;
    logic [YW-1:0]        y_q;
    logic [CHR_W-1:0]     chr_q;
    logic                 str_q, rerr_q;

    assign accept_en = (state == ST_IDLE) && !rst_sys;

    rr_arbiter #(.N(N_CLIENTS)) u_arb (
        .clk     (clk_sys),
        .rst     (rst_sys),
        .req     (tc.req_valid & {N_CLIENTS{accept_en}}),
        .advance (accept),
        .grant   (grant)
    );

    assign tc.req_ready = grant;
    assign accept       = |grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (grant[i]) sel = SW'(i);
        end
    end

    assign sel_op   = text_op_t'(tc.req_op[sel]);
    assign sel_chr  = tc.req_chr[sel];
    assign sel_at   = '{x: tc.req_x[sel], y: tc.req_y[sel]};
    assign sel_cur  = cur[sel];
    assign in_range = (int'(sel_at.x) < COLS) && (int'(sel_at.y) < ROWS);
    assign clr_nxt  = cursor_step(clr_pos, COLS, ROWS);

    always_ff @(posedge clk_sys) begin
        if (rst_sys) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept && sel_op == OP_CLEAR) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_pos == LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // clr_pos always names the cell currently on the output during a CLEAR.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            x_q     <= '0;
            y_q     <= '0;
            chr_q   <= '0;
            str_q   <= 1'b0;
            rerr_q  <= 1'b0;
            clr_pos <= '0;
            clr_chr <= '0;
            for (int i = 0; i < N_CLIENTS; i++) cur[i] <= '0;
        end else begin
            str_q  <= 1'b0;
            rerr_q <= 1'b0;
            if (state == ST_CLEAR) begin
                if (clr_pos != LAST) begin
                    clr_pos <= clr_nxt;
                    x_q     <= clr_nxt.x;
                    y_q     <= clr_nxt.y;
                    chr_q   <= clr_chr;
                    str_q   <= 1'b1;
                end
            end else if (accept) begin
                case (sel_op)
                    OP_PUT_AT: begin
                        if (in_range) begin
                            x_q      <= sel_at.x;
                            y_q      <= sel_at.y;
                            chr_q    <= sel_chr;
                            str_q    <= 1'b1;
                            cur[sel] <= cursor_step(sel_at, COLS, ROWS);
                        end else begin
                            rerr_q <= 1'b1;
                        end
                    end
                    OP_PUT: begin
                        x_q      <= sel_cur.x;
                        y_q      <= sel_cur.y;
                        chr_q    <= sel_chr;
                        str_q    <= 1'b1;
                        cur[sel] <= cursor_step(sel_cur, COLS, ROWS);
                    end
                    OP_NEWLINE: cur[sel] <= cursor_newline(sel_cur, ROWS);
                    default: begin
                        cur[sel] <= '0;
                        clr_pos  <= '0;
                        clr_chr  <= sel_chr;
                        x_q      <= '0;
                        y_q      <= '0;
                        chr_q    <= sel_chr;
                        str_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tc.char_x    = x_q;
    assign tc.char_y    = y_q;
    assign tc.char_chr  = chr_q;
    assign tc.char_str  = str_q;
    assign tc.range_err = rerr_q;
    assign tc.busy      = (state == ST_CLEAR);
    assign tc.state_dbg = state;
endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: per-client command queues, a cursor/arbiter model
// and a due-cycle scoreboard of expected display strobes.
module tb_text_console;
    import flapjack_text_pkg::*;

    localparam int N    = 2;
    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int CW   = 9;
    localparam int W    = 54;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_console_if #(.N(N), .CHR_W(CW)) tc ();

    text_console #(.N_CLIENTS(N), .COLS(COLS), .ROWS(ROWS), .CHR_W(CW)) dut (
        .clk_sys (clk),
        .rst_sys (rst),
        .tc      (tc.slave)
    );

    // scoreboard entry: {due_cycle[31:0], x[6:0], y[5:0], chr[8:0]}
    logic [W-1:0]  exp_q[$];
    logic [23:0]   cmd_q[N][$];
    int            mx[N];
    int            my[N];
    int            ptr, clr_left, rerr_due, cyc;
    int            checks, failures;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push_cmd(int c, int op, int x, int y, int chr);
        cmd_q[c].push_back({2'(op), 7'(x), 6'(y), 9'(chr)});
    endtask

    task automatic push_exp(int due, int x, int y, int chr);
        exp_q.push_back({32'(due), 7'(x), 6'(y), 9'(chr)});
    endtask

    function automatic void adv(int c);
        if (mx[c] == COLS - 1) begin
            mx[c] = 0;
            my[c] = (my[c] == ROWS - 1) ? 0 : my[c] + 1;
        end else begin
            mx[c] = mx[c] + 1;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            mx[c] = 0;
            my[c] = 0;
        end
        ptr      = 0;
        clr_left = 0;
        rerr_due = -1;
    endfunction

    function automatic bit pending();
        bit p;
        p = (exp_q.size() > 0) || (clr_left > 0) || (rerr_due >= cyc);
        for (int c = 0; c < N; c++) if (cmd_q[c].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic model_accept(int g);
        logic [23:0] cmd;
        int op, ax, ay, ach;
        cmd = cmd_q[g].pop_front();
        op  = int'(cmd[23:22]);
        ax  = int'(cmd[21:15]);
        ay  = int'(cmd[14:9]);
        ach = int'(cmd[8:0]);
        ptr = (g + 1) % N;
        case (op)
            0: begin
                if (ax < COLS && ay < ROWS) begin
                    push_exp(cyc + 1, ax, ay, ach);
                    mx[g] = ax;
                    my[g] = ay;
                    adv(g);
                end else begin
                    rerr_due = cyc + 1;
                end
            end
            1: begin
                push_exp(cyc + 1, mx[g], my[g], ach);
                adv(g);
            end
            2: begin
                mx[g] = 0;
                my[g] = (my[g] == ROWS - 1) ? 0 : my[g] + 1;
            end
            default: begin
                for (int k = 0; k < COLS * ROWS; k++) push_exp(cyc + 1 + k, k % COLS, k / COLS, ach);
                mx[g]    = 0;
                my[g]    = 0;
                clr_left = COLS * ROWS;
            end
        endcase
    endtask

    // One clock: drive queue fronts, check outputs at negedge, predict grant, advance.
    task automatic cycle();
        logic [N-1:0] vld, exp_g;
        logic [23:0]  cmd;
        logic [W-1:0] e;
        bit           busy_now;
        int           g, cand;
        for (int c = 0; c < N; c++) begin
            vld[c] = (cmd_q[c].size() > 0);
            if (vld[c]) begin
                cmd           = cmd_q[c][0];
                tc.req_op[c]  = cmd[23:22];
                tc.req_x[c]   = cmd[21:15];
                tc.req_y[c]   = cmd[14:9];
                tc.req_chr[c] = cmd[8:0];
            end
            tc.req_valid[c] = vld[c];
        end
        @(negedge clk);
        busy_now = (clr_left > 0);
        if (exp_q.size() > 0 && int'(exp_q[0][53:22]) == cyc) begin
            e = exp_q.pop_front();
            check("strobe", tc.char_str, 1);
            check("cell", {tc.char_x, tc.char_y, tc.char_chr}, e[21:0]);
        end else begin
            check("no_strobe", tc.char_str, 0);
        end
        check("range_err", tc.range_err, rerr_due == cyc);
        check("busy", tc.busy, busy_now);
        g = -1;
        if (!rst && !busy_now) begin
            for (int i = 0; i < N; i++) begin
                cand = (ptr + i) % N;
                if (g < 0 && vld[cand]) g = cand;
            end
        end
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        check("ready", tc.req_ready, exp_g);
        if (busy_now) clr_left--;
        if (g >= 0) model_accept(g);
        if (rst) model_reset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        check("drain", pending(), 0);
        cycle();
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) cycle();
        check("rst_cell", {tc.char_x, tc.char_y, tc.char_chr}, 0);
        check("rst_state", tc.state_dbg, ST_IDLE);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        model_reset();
        tc.req_valid = '0;
        tc.req_op    = '0;
        tc.req_x     = '0;
        tc.req_y     = '0;
        tc.req_chr   = '0;
        @(posedge clk);
        #1;
        do_reset(3);

        // single PUT_AT, then a NEWLINE followed by PUT
        push_cmd(0, 0, 5, 3, 8'h41);
        run_idle(20);
        push_cmd(0, 2, 0, 0, 0);
        push_cmd(0, 1, 0, 0, 8'h42);
        run_idle(20);

        // PUT across the bottom-right corner wraps to (0,0)
        push_cmd(1, 0, 78, 59, 8'h79);
        push_cmd(1, 1, 0, 0, 8'h61);
        push_cmd(1, 1, 0, 0, 8'h62);
        push_cmd(1, 1, 0, 0, 8'h63);
        run_idle(20);

        // both clients contend: alternating grants, no bubbles
        for (int i = 0; i < 2; i++) begin
            push_cmd(0, 1, 0, 0, 8'h70 + i);
            push_cmd(1, 1, 0, 0, 8'h72 + i);
        end
        run_idle(20);

        // out-of-range PUT_AT leaves the cursor alone
        push_cmd(0, 0, 80, 0, 8'h78);
        push_cmd(0, 1, 0, 0, 8'h31);
        push_cmd(0, 0, 0, 60, 8'h78);
        push_cmd(0, 1, 0, 0, 8'h32);
        push_cmd(0, 0, 127, 63, 8'h78);
        run_idle(20);

        // full CLEAR with a PUT from client 1 waiting behind it
        push_cmd(0, 3, 0, 0, 8'h20);
        cycle();
        push_cmd(1, 1, 0, 0, 8'h5a);
        run_idle(6000);
        push_cmd(0, 1, 0, 0, 8'h30);
        run_idle(20);

        // randomized mix on both clients
        for (int i = 0; i < 40; i++) begin
            push_cmd($urandom_range(0, N - 1), $urandom_range(0, 2), $urandom_range(0, 85),
                     $urandom_range(0, 63), $urandom_range(0, 511));
        end
        run_idle(500);

        // reset in the middle of a CLEAR at cell 100
        push_cmd(1, 1, 0, 0, 8'h44);
        run_idle(20);
        push_cmd(0, 3, 0, 0, 8'h2e);
        repeat (101) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("abort_cell", {tc.char_x, tc.char_y, tc.char_chr}, 0);
        push_cmd(1, 1, 0, 0, 8'h71);
        run_idle(20);
        push_cmd(0, 1, 0, 0, 8'h72);
        run_idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
